// File: rtl/alu_iter_mul.sv
// Single-cycle ALU with a 32-step radix-2 shift-add multiplier.
// Combinational ops finish in the issue cycle; MUL stalls the CPU until its DONE cycle.
module alu_iter_mul #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [3:0]       ALUCtl,
    input  logic             Sign,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] hi,
    output logic             zero,
    output logic             out_valid,
    output logic             stall
);

    localparam int unsigned CntW = $clog2(WIDTH) + 1;

    localparam logic [3:0] CtlSub = 4'd1;
    localparam logic [3:0] CtlMul = 4'd2;
    localparam logic [3:0] CtlAnd = 4'd4;
    localparam logic [3:0] CtlOr  = 4'd5;
    localparam logic [3:0] CtlXor = 4'd6;
    localparam logic [3:0] CtlNor = 4'd7;
    localparam logic [3:0] CtlSll = 4'd8;
    localparam logic [3:0] CtlSrl = 4'd9;
    localparam logic [3:0] CtlSra = 4'd10;
    localparam logic [3:0] CtlSlt = 4'd11;

    typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic               neg_q, neg_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d;

    logic [4:0]         shamt;
    logic               slt;
    logic [WIDTH-1:0]   alu_res;
    logic [2*WIDTH-1:0] mcand_ext;
    logic [2*WIDTH-1:0] acc_step;
    logic [2*WIDTH-1:0] prod_step;
    logic [2*WIDTH-1:0] prod;

    assign shamt = in1[4:0];
    assign slt   = Sign ? ($signed(in1) < $signed(in2)) : (in1 < in2);

    // Combinational path; unknown codes (and MUL outside of DONE) fall back to ADD.
    always_comb begin
        alu_res = in1 + in2;
        case (ALUCtl)
            CtlSub:  alu_res = in1 - in2;
            CtlAnd:  alu_res = in1 & in2;
            CtlOr:   alu_res = in1 | in2;
            CtlXor:  alu_res = in1 ^ in2;
            CtlNor:  alu_res = ~(in1 | in2);
            CtlSll:  alu_res = in2 << shamt;
            CtlSrl:  alu_res = in2 >> shamt;
            CtlSra:  alu_res = WIDTH'($signed(in2) >>> shamt);
            CtlSlt:  alu_res = {{(WIDTH-1){1'b0}}, slt};
            default: alu_res = in1 + in2;
        endcase
    end

    assign mcand_ext = {{WIDTH{1'b0}}, mcand_q};
    assign acc_step  = mplier_q[0] ? (acc_q + (mcand_ext << cnt_q)) : acc_q;
    assign prod_step = neg_q ? (~acc_step + 1'b1) : acc_step;
    assign prod      = neg_q ? (~acc_q + 1'b1) : acc_q;

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        neg_d     = neg_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        stall     = 1'b0;
        out_valid = 1'b0;
        out       = alu_res;
        case (state_q)
            StIdle: begin
                if (in_valid && (ALUCtl == CtlMul)) begin
                    stall    = 1'b1;
                    state_d  = StMul;
                    mcand_d  = (Sign && in1[WIDTH-1]) ? (~in1 + 1'b1) : in1;
                    mplier_d = (Sign && in2[WIDTH-1]) ? (~in2 + 1'b1) : in2;
                    neg_d    = Sign & (in1[WIDTH-1] ^ in2[WIDTH-1]);
                    acc_d    = '0;
                    cnt_d    = '0;
                end else begin
                    out_valid = in_valid;
                end
            end
            StMul: begin
                stall    = 1'b1;
                acc_d    = acc_step;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CntW'(1);
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    state_d = StDone;
                    hi_d    = prod_step[2*WIDTH-1:WIDTH];
                end
            end
            StDone: begin
                // Inputs still present the MUL here; never re-issue from DONE.
                out_valid = 1'b1;
                out       = prod[WIDTH-1:0];
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            mcand_q  <= '0;
            mplier_q <= '0;
            neg_q    <= 1'b0;
            acc_q    <= '0;
            cnt_q    <= '0;
            hi_q     <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            neg_q    <= neg_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
        end
    end

    assign hi   = hi_q;
    assign zero = (out == '0);

endmodule

// File: tb/tb_alu_iter_mul.sv
// Directed and randomized bench for alu_iter_mul against an arithmetic reference model.
module tb_alu_iter_mul;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [3:0]  ALUCtl;
    logic        Sign;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [31:0] out;
    logic [31:0] hi;
    logic        zero;
    logic        out_valid;
    logic        stall;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_hi = 32'h0;

    alu_iter_mul #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .ALUCtl    (ALUCtl),
        .Sign      (Sign),
        .in1       (in1),
        .in2       (in2),
        .out       (out),
        .hi        (hi),
        .zero      (zero),
        .out_valid (out_valid),
        .stall     (stall)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] ref_op(input logic [3:0] ctl, input logic s,
                                           input logic [31:0] a, input logic [31:0] b);
        logic [63:0] sext;
        int sh;
        sh   = int'(a[4:0]);
        sext = {{32{b[31]}}, b};
        case (ctl)
            4'd1:    return a - b;
            4'd4:    return a & b;
            4'd5:    return a | b;
            4'd6:    return a ^ b;
            4'd7:    return ~(a | b);
            4'd8:    return b << sh;
            4'd9:    return b >> sh;
            4'd10:   begin sext = sext >> sh; return sext[31:0]; end
            4'd11: begin
                if (s) return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                else   return (a < b) ? 32'd1 : 32'd0;
            end
            default: return a + b;
        endcase
    endfunction

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input logic s);
        longint sa, sb;
        logic [63:0] ua, ub;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        ua = {32'h0, a};
        ub = {32'h0, b};
        return ua * ub;
    endfunction

    task automatic comb_op(input logic [3:0] ctl, input logic s,
                           input logic [31:0] a, input logic [31:0] b);
        logic [31:0] e;
        in_valid = 1'b1; ALUCtl = ctl; Sign = s; in1 = a; in2 = b;
        #1;
        e = ref_op(ctl, s, a, b);
        chk($sformatf("op%0d_out", ctl), {32'h0, out}, {32'h0, e});
        chk("op_zero", {63'h0, zero}, {63'h0, (e == 32'h0)});
        chk("op_valid", {63'h0, out_valid}, 64'd1);
        chk("op_stall", {63'h0, stall}, 64'd0);
        chk("op_hi", {32'h0, hi}, {32'h0, exp_hi});
        tick;
    endtask

    // Leaves the MUL inputs applied on return (one cycle after DONE, state IDLE).
    task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [63:0] p;
        int n;
        in_valid = 1'b1; ALUCtl = 4'd2; Sign = s; in1 = a; in2 = b;
        #1;
        n = 0;
        while (stall === 1'b1 && n < 100) begin
            chk("mul_busy_valid", {63'h0, out_valid}, 64'd0);
            n++;
            tick;
        end
        p = ref_mul(a, b, s);
        exp_hi = p[63:32];
        chk("mul_stall_cycles", 64'(n), 64'd33);
        chk("mul_done_valid", {63'h0, out_valid}, 64'd1);
        chk("mul_done_stall", {63'h0, stall}, 64'd0);
        chk("mul_lo", {32'h0, out}, {32'h0, p[31:0]});
        chk("mul_hi", {32'h0, hi}, {32'h0, p[63:32]});
        chk("mul_zero", {63'h0, zero}, {63'h0, (p[31:0] == 32'h0)});
        tick;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; ALUCtl = 4'd0; Sign = 1'b0; in1 = '0; in2 = '0;
        tick;
        tick;
        reset = 1'b0;
        #1;
        chk("rst_stall", {63'h0, stall}, 64'd0);
        chk("rst_hi", {32'h0, hi}, 64'd0);
        chk("rst_valid", {63'h0, out_valid}, 64'd0);
        tick;

        comb_op(4'd0, 1'b0, 32'hFFFF_FFFF, 32'h1);
        comb_op(4'd1, 1'b0, 32'd5, 32'd7);
        comb_op(4'd10, 1'b0, 32'd4, 32'h8000_0000);
        comb_op(4'd11, 1'b1, 32'hFFFF_FFFF, 32'h1);
        comb_op(4'd11, 1'b0, 32'hFFFF_FFFF, 32'h1);
        comb_op(4'd7, 1'b0, 32'h0F0F_0000, 32'h00F0_F0F0);
        comb_op(4'd13, 1'b0, 32'd10, 32'd20);
        for (int i = 0; i < 24; i++) begin
            logic [3:0] c;
            c = 4'($urandom_range(0, 15));
            if (c == 4'd2) c = 4'd8;
            comb_op(c, 1'($urandom), $urandom, $urandom);
        end

        run_mul(32'hFFFF_FFFF, 32'd2, 1'b0);
        in_valid = 1'b0; tick;
        run_mul(32'hFFFF_FFFD, 32'd7, 1'b1);
        in_valid = 1'b0; tick;
        run_mul(32'h8000_0000, 32'h8000_0000, 1'b1);
        in_valid = 1'b0; tick;
        comb_op(4'd5, 1'b0, 32'h1234_0000, 32'h0000_5678);

        // Held inputs then back-to-back issue in the cycle after DONE.
        run_mul(32'h0001_0003, 32'h0002_0005, 1'b0);
        run_mul(32'hFFFF_FF00, 32'h0000_1234, 1'b1);
        in_valid = 1'b0; tick;

        for (int i = 0; i < 3; i++) begin
            run_mul($urandom, $urandom, 1'($urandom));
            in_valid = 1'b0; tick;
        end

        // Reset ten cycles into a MUL.
        in_valid = 1'b1; ALUCtl = 4'd2; Sign = 1'b0; in1 = 32'd99; in2 = 32'd77;
        for (int i = 0; i < 10; i++) tick;
        reset = 1'b1; in_valid = 1'b0;
        #1;
        chk("rst_mid_stall_in_reset", {63'h0, stall}, 64'd1);
        tick;
        reset = 1'b0;
        exp_hi = 32'h0;
        #1;
        chk("rst_mid_stall", {63'h0, stall}, 64'd0);
        chk("rst_mid_hi", {32'h0, hi}, 64'd0);
        chk("rst_mid_valid", {63'h0, out_valid}, 64'd0);
        tick;
        run_mul(32'd6, 32'd7, 1'b0);
        in_valid = 1'b0; tick;
        chk("final_hi_held", {32'h0, hi}, {32'h0, exp_hi});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_iter_mul.md
# alu_iter_mul

ALU that consumes the 4-bit operation code and `Sign` flag produced by the ALU control stage and returns the result to the writeback/branch logic of the single-cycle CPU. Every operation except multiply is combinational and completes in the issue cycle. Multiply is a radix-2 shift-add engine that takes 32 steps. While it runs, the block asserts `stall` so the CPU freezes PC and pipeline-visible state.

## Interface
- `WIDTH`, 32: operand/result width. Shift amount is always 5 bits.
- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high. Is the only reset.
- `in_valid` in 1: an instruction using the ALU is present this cycle.
- `ALUCtl` in 4: 0 ADD, 1 SUB, 2 MUL, 4 AND, 5 OR, 6 XOR, 7 NOR, 8 SLL, 9 SRL, 10 SRA, 11 SLT. Any other code executes ADD.
- `Sign` in 1: 1 selects signed SLT and a signed 64-bit product. 0 selects unsigned for both.
- `in1` in WIDTH: operand A. For shifts, `in1[4:0]` is the shift amount.
- `in2` in WIDTH: operand B. This is the value shifted by shifts.
- `out` out WIDTH: result.
- `hi` out WIDTH: upper half of the last completed 64-bit product. Held until the next product completes.
- `zero` out 1: `out == 0`.
- `out_valid` out 1: `out` is the final result for the current instruction.
- `stall` out 1: CPU must hold PC, register-file write enable and ALU inputs.

## Operation
- States: IDLE, MUL, DONE. Reset enters IDLE.
- **IDLE, non-MUL (or `in_valid=0`)**
  - `out` is computed combinationally, with all arithmetic modulo 2^WIDTH:
    - ADD: in1+in2. SUB: in1−in2.
    - AND, OR, XOR, NOR: bitwise on in1, in2.
    - SLL: in2 << in1[4:0]. SRL: logical right shift of in2 by in1[4:0]. SRA: arithmetic right shift of in2 by in1[4:0].
    - SLT: 1 if in1 < in2 (signed when `Sign=1`), else 0. Upper bits are 0.
  - `out_valid = in_valid`, `stall = 0`.
- **IDLE, `in_valid=1` and `ALUCtl=2`**
  - `stall=1` combinationally in this same cycle. `out_valid=0`.
  - At the clock edge, latch:
    - mcand = |in1|, mplier = |in2| (magnitudes only when `Sign=1` and the operand is negative);
    - neg = Sign & (in1[31] ^ in2[31]);
    - 64-bit accumulator = 0; step counter = 0.
  - Go to MUL.
- **MUL**
  - One step per cycle: if mplier[0], add mcand << step into the accumulator; shift mplier right by 1; increment the counter.
  - After step WIDTH−1 (the counter reaches WIDTH), go to DONE.
  - Inputs are ignored. `stall=1`, `out_valid=0`.
- **DONE**
  - Product = neg ? −acc : acc, in 64-bit two's complement.
  - `out` = product[31:0], combinational from the registered accumulator and neg. `hi` = product[63:32], registered on entry to DONE.
  - `stall=0`, `out_valid=1`. Return to IDLE at the next edge.
  - The CPU still presents the same MUL in DONE. The block must not restart it, so DONE never issues.
- **Reset mid-operation**
  - Next state IDLE; accumulator, counter, neg and `hi` cleared to 0. No result is produced.
  - In the reset cycle itself, `stall` follows normal decode.

## Timing
- **Reset values:**
  - `hi`=0.
  - State IDLE, so the state-driven outputs take their IDLE values.
  - `out`, `zero` and `out_valid` follow the IDLE combinational path.
- **Non-MUL:** latency 0 cycles, no stall.
- **MUL:**
  - Issued in cycle T; `stall=1` in cycles T through T+WIDTH.
  - Result with `out_valid=1`, `stall=0` in cycle T+WIDTH+1, which is 33 cycles for WIDTH=32.
  - Back-to-back MULs: the second may issue in the cycle after DONE.
- **`zero`:** always reflects the current `out`. In MUL it reflects the IDLE-path value and must be ignored.
- **Back-pressure:** none; `stall` is the only one.

## Test plan
- **Reset:** hold `reset` for 2 cycles, then release with `in_valid=0` -> `stall=0`, `hi=0`, state IDLE.
- **Combinational ops:**
  - ADD 0xFFFFFFFF+1 -> `out=0`, `zero=1`.
  - SUB 5−7 -> 0xFFFFFFFE.
  - SRA in2=0x80000000, in1[4:0]=4 -> 0xF8000000.
  - SLT 0xFFFFFFFF vs 1: `Sign=1` -> 1, `Sign=0` -> 0.
  - All with `stall=0` and `out_valid=1` in the same cycle.
- **Unsigned MUL:** 0xFFFFFFFF×2, `Sign=0` -> `stall` high exactly 33 cycles, then one cycle with `out=0xFFFFFFFE`, `hi=0x00000001`, `out_valid=1`.
- **Signed MUL:** −3×7, `Sign=1` -> `out=0xFFFFFFEB`, `hi=0xFFFFFFFF`. Also 0x80000000×0x80000000 signed -> `out=0`, `hi=0x40000000`.
- **Held inputs:** MUL inputs held through DONE, followed by a second MUL issued in the cycle after DONE -> exactly two 33-cycle stall windows separated by one non-stall cycle; no spurious restart.
- **Reset mid-MUL:** assert `reset` 10 cycles into a MUL -> next cycle IDLE, `stall=0` with `in_valid=0`, `hi=0`. A new MUL 6×7 then yields `out=42`.
